// File: rtl/peripheral_axi4_burst_gen.sv
// AXI4 burst address generator: expands one AW/AR command into per-beat addr/strb/idx/last, then OKAY or SLVERR.
// Latency: command edge T, legality check during T+1, first beat (or error response) registered at T+2, one beat/cycle.
// Backpressure: beat outputs hold while beat_ready=0; response holds until rsp_ready; one command in flight at a time.
module peripheral_axi4_burst_gen #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic [2:0]              cmd_size,
    input  logic [1:0]              cmd_burst,
    output logic                    beat_valid,
    input  logic                    beat_ready,
    output logic [ADDR_WIDTH-1:0]   beat_addr,
    output logic [DATA_WIDTH/8-1:0] beat_strb,
    output logic [LEN_WIDTH-1:0]    beat_idx,
    output logic                    beat_last,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_resp
);
    localparam int NB      = DATA_WIDTH / 8;
    localparam int NB_LOG2 = $clog2(NB);
    localparam int SUM_W   = 13 + LEN_WIDTH + 7;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_BURST, S_RESP} state_t;

    state_t                 state, state_nxt;
    cmd_t                   cmd_q, cmd_nxt;
    logic                   cmd_ready_nxt;
    logic                   beat_valid_nxt, beat_last_nxt;
    logic [ADDR_WIDTH-1:0]  beat_addr_nxt, addr_adv;
    logic [NB-1:0]          beat_strb_nxt;
    logic [LEN_WIDTH-1:0]   beat_idx_nxt;
    logic                   rsp_valid_nxt;
    logic [1:0]             rsp_resp_nxt;

    function automatic logic [ADDR_WIDTH-1:0] size_mask(input logic [2:0] size);
        return (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
    endfunction

    function automatic logic [NB-1:0] lane_strb(input logic [ADDR_WIDTH-1:0] addr, input logic [2:0] size);
        logic [ADDR_WIDTH-1:0] lo, hi;
        logic [NB-1:0]         s;
        lo = addr & ADDR_WIDTH'(NB - 1);
        hi = ((addr & ~size_mask(size)) & ADDR_WIDTH'(NB - 1)) + size_mask(size);
        for (int i = 0; i < NB; i++) begin
            s[i] = (ADDR_WIDTH'(i) >= lo) && (ADDR_WIDTH'(i) <= hi);
        end
        return s;
    endfunction

    function automatic logic cmd_illegal(input cmd_t c);
        logic [11:0]      a12;
        logic [SUM_W-1:0] span_end;
        logic             wrap_len_ok;
        a12 = c.addr[11:0] & ~((12'd1 << c.size) - 12'd1);
        span_end = SUM_W'(a12) + ((SUM_W'(c.len) + SUM_W'(1)) << c.size);
        wrap_len_ok = (c.len == LEN_WIDTH'(1)) || (c.len == LEN_WIDTH'(3)) ||
                      (c.len == LEN_WIDTH'(7)) || (c.len == LEN_WIDTH'(15));
        return (c.burst == 2'b11) ||
               (32'(c.size) > NB_LOG2) ||
               ((c.burst == BURST_FIXED) && (c.len > LEN_WIDTH'(15))) ||
               ((c.burst == BURST_WRAP) && !wrap_len_ok) ||
               ((c.burst == BURST_WRAP) && ((c.addr & size_mask(c.size)) != '0)) ||
               ((c.burst == BURST_INCR) && (span_end > SUM_W'(4096)));
    endfunction

    // WRAP wraps back to the window base once the next beat would reach its top.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input cmd_t c, input logic [ADDR_WIDTH-1:0] cur);
        logic [ADDR_WIDTH-1:0] bytes, wsz, lower, nxt;
        bytes = ADDR_WIDTH'(1) << c.size;
        wsz   = (ADDR_WIDTH'(c.len) + ADDR_WIDTH'(1)) << c.size;
        lower = cur & ~(wsz - ADDR_WIDTH'(1));
        case (c.burst)
            BURST_FIXED: nxt = cur;
            BURST_WRAP: begin
                nxt = cur + bytes;
                if (nxt == lower + wsz) nxt = lower;
            end
            default:     nxt = (cur & ~size_mask(c.size)) + bytes;
        endcase
        return nxt;
    endfunction

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            cmd_q      <= '0;
            cmd_ready  <= 1'b0;
            beat_valid <= 1'b0;
            beat_addr  <= '0;
            beat_strb  <= '0;
            beat_idx   <= '0;
            beat_last  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_resp   <= RESP_OKAY;
        end else begin
            state      <= state_nxt;
            cmd_q      <= cmd_nxt;
            cmd_ready  <= cmd_ready_nxt;
            beat_valid <= beat_valid_nxt;
            beat_addr  <= beat_addr_nxt;
            beat_strb  <= beat_strb_nxt;
            beat_idx   <= beat_idx_nxt;
            beat_last  <= beat_last_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_resp   <= rsp_resp_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cmd_nxt        = cmd_q;
        cmd_ready_nxt  = cmd_ready;
        beat_valid_nxt = beat_valid;
        beat_addr_nxt  = beat_addr;
        beat_strb_nxt  = beat_strb;
        beat_idx_nxt   = beat_idx;
        beat_last_nxt  = beat_last;
        rsp_valid_nxt  = rsp_valid;
        rsp_resp_nxt   = rsp_resp;
        addr_adv       = next_addr(cmd_q, beat_addr);

        case (state)
            S_IDLE: begin
                cmd_ready_nxt = 1'b1;
                if (cmd_ready && cmd_valid) begin
                    cmd_nxt.addr  = cmd_addr;
                    cmd_nxt.len   = cmd_len;
                    cmd_nxt.size  = cmd_size;
                    cmd_nxt.burst = cmd_burst;
                    cmd_ready_nxt = 1'b0;
                    state_nxt     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cmd_illegal(cmd_q)) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_resp_nxt  = RESP_SLVERR;
                    state_nxt     = S_RESP;
                end else begin
                    beat_valid_nxt = 1'b1;
                    beat_addr_nxt  = cmd_q.addr;
                    beat_strb_nxt  = lane_strb(cmd_q.addr, cmd_q.size);
                    beat_idx_nxt   = '0;
                    beat_last_nxt  = (cmd_q.len == '0);
                    state_nxt      = S_BURST;
                end
            end
            S_BURST: begin
                if (beat_ready) begin
                    if (beat_last) begin
                        beat_valid_nxt = 1'b0;
                        beat_last_nxt  = 1'b0;
                        rsp_valid_nxt  = 1'b1;
                        rsp_resp_nxt   = RESP_OKAY;
                        state_nxt      = S_RESP;
                    end else begin
                        beat_addr_nxt = addr_adv;
                        beat_strb_nxt = lane_strb(addr_adv, cmd_q.size);
                        beat_idx_nxt  = beat_idx + LEN_WIDTH'(1);
                        beat_last_nxt = ((beat_idx + LEN_WIDTH'(1)) == cmd_q.len);
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_peripheral_axi4_burst_gen.sv
// Bench for peripheral_axi4_burst_gen: expected beats/responses queued at issue, popped by a monitor on each handshake.
// Latency: checks CHECK cycle and T+2 first output directly in the stimulus thread.
// Backpressure: drives beat_ready/rsp_ready stall patterns and checks outputs hold.
module tb_peripheral_axi4_burst_gen;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid, cmd_ready;
    logic [63:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        beat_valid, beat_ready;
    logic [63:0] beat_addr;
    logic [7:0]  beat_strb;
    logic [7:0]  beat_idx;
    logic        beat_last;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_resp;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [7:0]  idx;
        logic        last;
    } beat_t;

    beat_t      exp_beats[$];
    logic [1:0] exp_rsp[$];
    int         checks = 0;
    int         errors = 0;

    peripheral_axi4_burst_gen #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .LEN_WIDTH(8)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
        .beat_strb(beat_strb), .beat_idx(beat_idx), .beat_last(beat_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic pb(input logic [63:0] a, input logic [7:0] s, input logic [7:0] i, input logic l);
        beat_t b;
        b.addr = a; b.strb = s; b.idx = i; b.last = l;
        exp_beats.push_back(b);
    endtask

    // Monitor: all DUT outputs are registered, so sampling at the falling edge sees the values the next rising edge uses.
    always @(negedge aclk) begin
        if (aresetn && beat_valid && rsp_valid) begin
            errors++;
            $display("FAIL overlap beat_valid=1 rsp_valid=1 expected never both");
        end
        if (aresetn && beat_valid && beat_ready) begin
            if (exp_beats.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat addr=%0h idx=%0d expected no beat", beat_addr, beat_idx);
            end else begin
                beat_t e;
                e = exp_beats.pop_front();
                chk("beat_addr", beat_addr, e.addr);
                chk("beat_strb", 64'(beat_strb), 64'(e.strb));
                chk("beat_idx", 64'(beat_idx), 64'(e.idx));
                chk("beat_last", 64'(beat_last), 64'(e.last));
            end
        end
        if (aresetn && rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp resp=%0h expected no response", rsp_resp);
            end else begin
                logic [1:0] r;
                r = exp_rsp.pop_front();
                chk("rsp_resp", 64'(rsp_resp), 64'(r));
            end
        end
    end

    task automatic run_cmd(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic legal);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b;
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        chk("check_cycle_beat_valid", 64'(beat_valid), 64'd0);
        chk("check_cycle_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("check_cycle_cmd_ready", 64'(cmd_ready), 64'd0);
        @(posedge aclk); #1;
        chk("t2_beat_valid", 64'(beat_valid), 64'(legal));
        chk("t2_rsp_valid", 64'(rsp_valid), 64'(!legal));
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_beats.size() != 0 || exp_rsp.size() != 0 || !cmd_ready) && n < 200) begin
            @(posedge aclk); #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_timeout beats_left=%0d rsps_left=%0d expected 0/0", name,
                     exp_beats.size(), exp_rsp.size());
            exp_beats.delete();
            exp_rsp.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout expected run to finish");
        $fatal(1, "timeout");
    end

    initial begin
        aresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
        beat_ready = 1'b1; rsp_ready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_beat_valid", 64'(beat_valid), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_beat_addr", beat_addr, 64'd0);
        chk("rst_rsp_resp", 64'(rsp_resp), 64'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // INCR aligned
        pb(64'h1004, 8'hF0, 8'd0, 1'b0); pb(64'h1008, 8'h0F, 8'd1, 1'b0);
        pb(64'h100C, 8'hF0, 8'd2, 1'b0); pb(64'h1010, 8'h0F, 8'd3, 1'b1);
        exp_rsp.push_back(2'b00);
        run_cmd(64'h1004, 8'd3, 3'd2, 2'b01, 1'b1);
        wait_done("incr");

        // INCR unaligned start
        pb(64'h1006, 8'hC0, 8'd0, 1'b0); pb(64'h1008, 8'h0F, 8'd1, 1'b1);
        exp_rsp.push_back(2'b00);
        run_cmd(64'h1006, 8'd1, 3'd2, 2'b01, 1'b1);
        wait_done("incr_unaligned");

        // WRAP
        pb(64'h38, 8'hFF, 8'd0, 1'b0); pb(64'h20, 8'hFF, 8'd1, 1'b0);
        pb(64'h28, 8'hFF, 8'd2, 1'b0); pb(64'h30, 8'hFF, 8'd3, 1'b1);
        exp_rsp.push_back(2'b00);
        run_cmd(64'h38, 8'd3, 3'd3, 2'b10, 1'b1);
        wait_done("wrap");

        // Illegal commands
        exp_rsp.push_back(2'b10); run_cmd(64'hFF8, 8'd1, 3'd3, 2'b01, 1'b0); wait_done("err_4k");
        exp_rsp.push_back(2'b10); run_cmd(64'h0, 8'd0, 3'd4, 2'b01, 1'b0); wait_done("err_size");
        exp_rsp.push_back(2'b10); run_cmd(64'h0, 8'd0, 3'd3, 2'b11, 1'b0); wait_done("err_burst");
        exp_rsp.push_back(2'b10); run_cmd(64'h0, 8'd2, 3'd3, 2'b10, 1'b0); wait_done("err_wrap_len");
        exp_rsp.push_back(2'b10); run_cmd(64'h0, 8'd16, 3'd3, 2'b00, 1'b0); wait_done("err_fixed_len");

        // FIXED with beat stalls and response hold
        pb(64'h40, 8'hFF, 8'd0, 1'b0); pb(64'h40, 8'hFF, 8'd1, 1'b0); pb(64'h40, 8'hFF, 8'd2, 1'b1);
        exp_rsp.push_back(2'b00);
        beat_ready = 1'b1; rsp_ready = 1'b0;
        run_cmd(64'h40, 8'd2, 3'd3, 2'b00, 1'b1);
        @(posedge aclk); #1;
        beat_ready = 1'b0;
        repeat (2) begin
            @(posedge aclk); #1;
            chk("stall_beat_valid", 64'(beat_valid), 64'd1);
            chk("stall_beat_addr", beat_addr, 64'h40);
            chk("stall_beat_idx", 64'(beat_idx), 64'd1);
            chk("stall_beat_strb", 64'(beat_strb), 64'hFF);
        end
        beat_ready = 1'b1;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("hold_beat_valid", 64'(beat_valid), 64'd0);
        repeat (2) begin
            @(posedge aclk); #1;
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rsp_resp", 64'(rsp_resp), 64'd0);
            chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        wait_done("fixed_stall");

        // Reset during beat 2 of an 8-beat INCR
        pb(64'h2000, 8'hFF, 8'd0, 1'b0); pb(64'h2008, 8'hFF, 8'd1, 1'b0);
        run_cmd(64'h2000, 8'd7, 3'd3, 2'b01, 1'b1);
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        chk("pre_rst_beat_idx", 64'(beat_idx), 64'd2);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        chk("midrst_beat_valid", 64'(beat_valid), 64'd0);
        chk("midrst_beat_addr", beat_addr, 64'd0);
        chk("midrst_beat_strb", 64'(beat_strb), 64'd0);
        chk("midrst_beat_idx", 64'(beat_idx), 64'd0);
        chk("midrst_beat_last", 64'(beat_last), 64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
        @(posedge aclk); #1;
        chk("after_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("after_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("after_rst_beats_left", 64'(exp_beats.size()), 64'd0);
        pb(64'h3000, 8'hFF, 8'd0, 1'b0); pb(64'h3008, 8'hFF, 8'd1, 1'b1);
        exp_rsp.push_back(2'b00);
        run_cmd(64'h3000, 8'd1, 3'd3, 2'b01, 1'b1);
        wait_done("after_reset");

        repeat (5) @(posedge aclk);
        #1;
        chk("final_beats_left", 64'(exp_beats.size()), 64'd0);
        chk("final_rsps_left", 64'(exp_rsp.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
